mult_fu: RTL and testbench

// - Iterative RV32M multiply functional unit; sits between the mult reservation station and the CDB arbiter.
// - Accepts one MUL/MULH/MULHSU/MULHU op, computes it over multiple cycles, then holds the result with done=1.
// - Holds until the arbiter acks the result; one instance per mult_done/mult_output_data slot of the arbiter.

---
 rtl/mult_fu_pkg.sv | 37 +++
 rtl/mult_core_iter.sv | 49 ++++
 rtl/mult_fu.sv | 113 +++++++++++
 tb/tb_mult_fu.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_fu_pkg.sv
// Shared types for the iterative RV32M multiply unit:
// issue bundle, CDB result bundle, MUL funct3 codes.
package mult_fu_pkg;

   typedef enum logic [2:0] {
      MUL_F3    = 3'b000,
      MULH_F3   = 3'b001,
      MULHSU_F3 = 3'b010,
      MULHU_F3  = 3'b011
   } mul_f3_t;

   typedef struct packed {
      logic [2:0]  funct3;
      logic [31:0] rs1_v;
      logic [31:0] rs2_v;
      logic [5:0]  pd_s;
      logic [3:0]  rob_num;
      logic [31:0] rvfi_data;
   } mult_issue_t;

   typedef struct packed {
      logic [5:0]  pd_s;
      logic [3:0]  rob_num;
      logic [31:0] pd_v;
      logic [31:0] rvfi_data;
      logic        br_en;
      logic [31:0] br_target;
   } fu_cdb_data_t;

   // -2^31 maps to 2^31, which still fits the unsigned 32-bit field.
   function automatic logic [32:0] mag33(input logic [31:0] v,
                                         input logic sgn);
      if (sgn && v[31]) return {1'b0, ~v + 32'd1};
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/mult_core_iter.sv
// Shift-and-add datapath: BPC multiplier bits per busy cycle
// into a 64-bit accumulator; exposes the next accumulator value.
module mult_core_iter
   import mult_fu_pkg::*;
#(
   parameter int BPC = 2,
   parameter int CW  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          busy,
   input  logic [32:0]   a_mag,
   input  logic [32:0]   b_mag,
   output logic [CW-1:0] counter,
   output logic [63:0]   product
);

   logic [63:0] acc;
   logic [63:0] mcand;
   logic [32:0] mplier;

   always_comb begin
      product = acc;
      for (int k = 0; k < BPC; k++) begin
         if (mplier[k]) product = product + (mcand << k);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
      end else if (start) begin
         counter <= '0;
         acc     <= '0;
         mcand   <= {31'd0, a_mag};
         mplier  <= b_mag;
      end else if (busy) begin
         counter <= counter + CW'(1);
         acc     <= product;
         mcand   <= mcand << BPC;
         mplier  <= mplier >> BPC;
      end
   end

endmodule

// File: rtl/mult_fu.sv
// Iterative MUL/MULH/MULHSU/MULHU unit: accepts one op,
// iterates, then holds the result on the CDB port until acked.
module mult_fu
   import mult_fu_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         issue_valid,
   output logic         issue_ready,
   input  mult_issue_t  issue,
   output logic         done,
   output fu_cdb_data_t output_data,
   input  logic         ack
);

   localparam int ITERS = 32 / BITS_PER_CYCLE;
   localparam int CW    = $clog2(ITERS + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic          accept, last;
   logic          s1, s2, neg_d;
   logic          neg_q, hi_q;
   logic [32:0]   a_mag, b_mag;
   logic [CW-1:0] counter;
   logic [63:0]   prod, fixed;
   logic [31:0]   pd_v_q;
   logic [5:0]    pd_s_q;
   logic [3:0]    rob_q;
   logic [31:0]   rvfi_q;

   assign issue_ready = (state_q == IDLE);
   assign done        = (state_q == DONE);
   assign accept      = issue_valid && issue_ready && !flush;
   assign last        = (state_q == BUSY) && (counter == CW'(ITERS - 1));

   always_comb begin
      s1 = 1'b0;
      s2 = 1'b0;
      unique case (issue.funct3)
         MUL_F3, MULH_F3: begin
            s1 = 1'b1;
            s2 = 1'b1;
         end
         MULHSU_F3: s1 = 1'b1;
         default: ;
      endcase
   end

   assign a_mag = mag33(issue.rs1_v, s1);
   assign b_mag = mag33(issue.rs2_v, s2);
   assign neg_d = (s1 & issue.rs1_v[31]) ^ (s2 & issue.rs2_v[31]);

   mult_core_iter #(
      .BPC (BITS_PER_CYCLE),
      .CW  (CW)
   ) u_core (
      .clk     (clk),
      .rst     (rst || flush),
      .start   (accept),
      .busy    (state_q == BUSY),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .counter (counter),
      .product (prod)
   );

   assign fixed = neg_q ? (~prod + 64'd1) : prod;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (issue_valid) state_d = BUSY;
         BUSY: if (last) state_d = DONE;
         DONE: if (ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Payload registers carry no reset; they are only read while done=1.
   always_ff @(posedge clk) begin
      if (accept) begin
         neg_q  <= neg_d;
         hi_q   <= (issue.funct3 != MUL_F3);
         pd_s_q <= issue.pd_s;
         rob_q  <= issue.rob_num;
         rvfi_q <= issue.rvfi_data;
      end
      if (last && !flush && !rst) begin
         pd_v_q <= hi_q ? fixed[63:32] : fixed[31:0];
      end
   end

   always_comb begin
      output_data           = '0;
      output_data.pd_s      = pd_s_q;
      output_data.rob_num   = rob_q;
      output_data.pd_v      = pd_v_q;
      output_data.rvfi_data = rvfi_q;
      output_data.br_en     = 1'b0;
   end

endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: vector table plus hand-written
// hold, flush and reset sequences.
module tb_mult_fu;
   import mult_fu_pkg::*;

   logic         clk = 1'b0;
   logic         rst, flush, issue_valid, ack;
   logic         issue_ready, done;
   mult_issue_t  issue;
   fu_cdb_data_t output_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[14];

   logic [5:0]  exp_pd_s;
   logic [3:0]  exp_rob;
   logic [31:0] exp_rvfi;

   mult_fu dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue       (issue),
      .done        (done),
      .output_data (output_data),
      .ack         (ack)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
      end
   endtask

   task automatic drive_issue(input logic [2:0] f3,
                              input logic [31:0] a,
                              input logic [31:0] b);
      exp_pd_s = 6'($urandom);
      exp_rob  = 4'($urandom);
      exp_rvfi = $urandom;
      issue.funct3    = f3;
      issue.rs1_v     = a;
      issue.rs2_v     = b;
      issue.pd_s      = exp_pd_s;
      issue.rob_num   = exp_rob;
      issue.rvfi_data = exp_rvfi;
      issue_valid     = 1'b1;
      cyc();
      issue_valid = 1'b0;
      issue       = '0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 40) begin
         cyc();
         n++;
      end
      chk({name, " latency"}, 32'(n), 32'd16);
   endtask

   task automatic chk_result(input string name,
                             input logic [31:0] exp);
      chk({name, " done"}, 32'(done), 32'd1);
      chk({name, " pd_v"}, output_data.pd_v, exp);
      chk({name, " pd_s"}, 32'(output_data.pd_s), 32'(exp_pd_s));
      chk({name, " rob"}, 32'(output_data.rob_num), 32'(exp_rob));
      chk({name, " rvfi"}, output_data.rvfi_data, exp_rvfi);
      chk({name, " br_en"}, 32'(output_data.br_en), 32'd0);
   endtask

   task automatic do_ack(input string name);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      chk({name, " done after ack"}, 32'(done), 32'd0);
      chk({name, " ready after ack"}, 32'(issue_ready), 32'd1);
   endtask

   task automatic run_op(input string name, input vec_t v);
      drive_issue(v.f3, v.a, v.b);
      wait_done(name);
      chk_result(name, v.exp);
      do_ack(name);
   endtask

   initial begin
      vt[0]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vt[1]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
      vt[2]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
      vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[4]  = '{3'b000, 32'h12345678, 32'h00000000, 32'h00000000};
      vt[5]  = '{3'b001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vt[6]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      vt[7]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vt[8]  = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
      vt[9]  = '{3'b011, 32'h80000000, 32'h00000002, 32'h00000001};
      vt[10] = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000000};
      vt[11] = '{3'b001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
      vt[12] = '{3'b000, 32'd12345,    32'hFFFFFFFF, 32'hFFFFCFC7};
      vt[13] = '{3'b011, 32'd3,        32'd5,        32'h00000000};

      rst = 1'b1;
      flush = 1'b0;
      issue_valid = 1'b0;
      ack = 1'b0;
      issue = '0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("reset done", 32'(done), 32'd0);
      chk("reset ready", 32'(issue_ready), 32'd1);

      for (int i = 0; i < 14; i++) begin
         run_op($sformatf("vec%0d", i), vt[i]);
      end

      begin : hold_seq
         logic [$bits(fu_cdb_data_t)-1:0] snap;
         logic stable;
         drive_issue(3'b000, 32'd100, 32'd200);
         wait_done("hold");
         chk_result("hold", 32'd20000);
         snap = output_data;
         stable = 1'b1;
         issue.funct3 = 3'b011;
         issue.rs1_v  = 32'hDEADBEEF;
         issue.rs2_v  = 32'h12345678;
         issue_valid  = 1'b1;
         for (int k = 0; k < 5; k++) begin
            cyc();
            if (output_data !== snap || !done || issue_ready)
               stable = 1'b0;
         end
         issue_valid = 1'b0;
         issue = '0;
         chk("hold stable", 32'(stable), 32'd1);
         chk_result("hold end", 32'd20000);
         do_ack("hold");
         cyc();
         chk("hold no stray op", 32'(issue_ready), 32'd1);
      end

      begin : flush_busy
         logic saw_done;
         drive_issue(3'b000, 32'd9, 32'd9);
         for (int k = 0; k < 6; k++) cyc();
         flush = 1'b1;
         cyc();
         flush = 1'b0;
         chk("flush busy ready", 32'(issue_ready), 32'd1);
         chk("flush busy done", 32'(done), 32'd0);
         saw_done = 1'b0;
         for (int k = 0; k < 20; k++) begin
            cyc();
            if (done) saw_done = 1'b1;
         end
         chk("flush busy no done", 32'(saw_done), 32'd0);
         run_op("after flush", vt[1]);
      end

      drive_issue(3'b001, 32'h80000000, 32'h80000000);
      wait_done("flush ack");
      chk_result("flush ack", 32'h40000000);
      flush = 1'b1;
      ack = 1'b1;
      cyc();
      flush = 1'b0;
      ack = 1'b0;
      chk("flush ack done", 32'(done), 32'd0);
      chk("flush ack ready", 32'(issue_ready), 32'd1);

      issue.funct3 = 3'b000;
      issue.rs1_v  = 32'd5;
      issue.rs2_v  = 32'd5;
      issue_valid  = 1'b1;
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      issue_valid = 1'b0;
      issue = '0;
      chk("flush drops issue", 32'(issue_ready), 32'd1);

      drive_issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int k = 0; k < 5; k++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst busy done", 32'(done), 32'd0);
      chk("rst busy ready", 32'(issue_ready), 32'd1);
      run_op("after rst", vt[3]);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
